// File: rtl/speed_governor.sv
// Vehicle speed governor: key/lever/pedal inputs to a bounded speed count.
// Optional engine braking above the gear window: SPEED_GOV_ENGINE_BRAKE_EN.
module speed_governor #(
  parameter int SPEED_W   = 7,
  parameter int MAX_SPEED = 99,
  parameter int GEAR_W    = 3,
  parameter int NUM_GEARS = 5,
  parameter int REV_CODE  = 6,
  parameter int WIN_STEP  = 20,
  parameter int WIN_OFS   = 5,
  parameter int REV_MAX   = 20,
  parameter int TICK_DIV  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_on,
  input  logic              accel,
  input  logic              brake,
  input  logic [GEAR_W-1:0] gear,
  output logic [SPEED_W-1:0] speed,
  output logic [GEAR_W-1:0] eff_gear,
  output logic              reverse,
  output logic              gear_fault
);

  localparam int AW = SPEED_W + GEAR_W + 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [AW-1:0] C_STEP = AW'(WIN_STEP);
  localparam logic [AW-1:0] C_OFS  = AW'(WIN_OFS);
  localparam logic [AW-1:0] C_MAX  = AW'(MAX_SPEED);
  localparam logic [AW-1:0] C_LOB  = AW'(WIN_STEP + WIN_OFS);

  localparam logic [SPEED_W-1:0] C_RMAX = SPEED_W'(REV_MAX);
  localparam logic [SPEED_W-1:0] C_ONE  = SPEED_W'(1);
  localparam logic [SPEED_W-1:0] C_FIVE = SPEED_W'(5);
  localparam logic [SPEED_W-1:0] C_TEN  = SPEED_W'(10);

  localparam logic [GEAR_W-1:0] C_REV = GEAR_W'(REV_CODE);
  localparam logic [GEAR_W-1:0] C_NG  = GEAR_W'(NUM_GEARS);
  localparam logic [TW-1:0]     C_TL  = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_OFF,
    S_FWD,
    S_REV
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [TW-1:0]      r_tick;
  logic [SPEED_W-1:0] r_speed;
  logic [GEAR_W-1:0]  r_eff_gear;
  logic               r_fault;

  logic               w_tick;
  logic [SPEED_W-1:0] w_speed_nxt;
  logic [GEAR_W-1:0]  w_eff_nxt;
  logic               w_fault;
  logic               w_is_rev;
  logic               w_moving;
  logic               w_fwd_gear;

  logic [AW-1:0] w_spd_x;
  logic [AW-1:0] w_base;
  logic [AW-1:0] w_hi_raw;
  logic [AW-1:0] w_hi;
  logic [AW-1:0] w_lo;
  logic          w_gt_lo;
  logic          w_lt_hi;
  logic          w_gt_hi;

  assign w_tick = (r_tick == C_TL);

  // Window bounds in widened arithmetic, clamped to 0..MAX_SPEED.
  assign w_spd_x  = AW'(r_speed);
  assign w_base   = C_STEP * AW'(gear);
  assign w_hi_raw = w_base + C_OFS;
  assign w_hi     = (w_hi_raw > C_MAX) ? C_MAX : w_hi_raw;
  assign w_lo     = (w_base >= C_LOB) ? (w_base - C_LOB) : '0;
  assign w_gt_lo  = (w_spd_x > w_lo);
  assign w_lt_hi  = (w_spd_x < w_hi);
  assign w_gt_hi  = (w_spd_x > w_hi);

  assign w_is_rev = (gear == C_REV);
  assign w_moving = (r_speed != '0);
  assign w_fault  = key_on & w_moving &
                    (((r_state == S_FWD) & w_is_rev) |
                     ((r_state == S_REV) & !w_is_rev));

  assign w_fwd_gear = (gear != '0) && (gear <= C_NG) && !w_fault;

  always_comb begin
    w_state_nxt = r_state;
    if (!key_on) begin
      w_state_nxt = S_OFF;
    end else begin
      unique case (r_state)
        S_OFF: w_state_nxt = S_FWD;
        S_FWD: if (w_is_rev && !w_moving) w_state_nxt = S_REV;
        S_REV: if (!w_is_rev && !w_moving) w_state_nxt = S_FWD;
        default: w_state_nxt = S_OFF;
      endcase
    end
  end

  always_comb begin
    w_speed_nxt = r_speed;
    unique case (r_state)
      S_OFF: begin
        if (brake) begin
          if (r_speed > C_TEN) w_speed_nxt = r_speed - C_TEN;
          else if (r_speed > C_FIVE) w_speed_nxt = r_speed - C_FIVE;
          else if (w_moving) w_speed_nxt = r_speed - C_ONE;
        end
      end
      S_FWD: begin
        if (w_fwd_gear) begin
          if (brake && w_gt_lo) w_speed_nxt = r_speed - C_ONE;
          else if (!brake && accel && w_lt_hi) w_speed_nxt = r_speed + C_ONE;
`ifdef SPEED_GOV_ENGINE_BRAKE_EN
          else if (w_gt_hi) w_speed_nxt = r_speed - C_ONE;
`endif
        end else if (brake && w_moving) begin
          w_speed_nxt = r_speed - C_ONE;
        end
      end
      S_REV: begin
        if (brake && w_moving) w_speed_nxt = r_speed - C_ONE;
        else if (!brake && !w_fault && accel && r_speed < C_RMAX)
          w_speed_nxt = r_speed + C_ONE;
      end
      default: w_speed_nxt = r_speed;
    endcase
  end

  always_comb begin
    w_eff_nxt = '0;
    if (w_state_nxt == S_FWD && w_fwd_gear) w_eff_nxt = gear;
    else if (w_state_nxt == S_REV && !w_fault) w_eff_nxt = C_REV;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_OFF;
      r_tick     <= '0;
      r_speed    <= '0;
      r_eff_gear <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick     <= w_tick ? '0 : r_tick + TW'(1);
      r_eff_gear <= w_eff_nxt;
      r_fault    <= w_fault;
      if (w_tick) r_speed <= w_speed_nxt;
    end
  end

  assign speed      = r_speed;
  assign eff_gear   = r_eff_gear;
  assign reverse    = (r_state == S_REV);
  assign gear_fault = r_fault;

endmodule

// File: tb/tb_speed_governor.sv
// Directed bench for speed_governor: default build plus a TICK_DIV=4 copy.
// Engine-brake expectations follow SPEED_GOV_ENGINE_BRAKE_EN.
module tb_speed_governor;

`ifdef SPEED_GOV_ENGINE_BRAKE_EN
  localparam int EB_MID   = 89;
  localparam int EB_FLOOR = 65;
`else
  localparam int EB_MID   = 99;
  localparam int EB_FLOOR = 99;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       key_on;
  logic       accel;
  logic       brake;
  logic [2:0] gear;
  logic [6:0] speed;
  logic [2:0] eff_gear;
  logic       reverse;
  logic       gear_fault;

  logic       b_rst;
  logic       b_key;
  logic       b_accel;
  logic       b_brake;
  logic [2:0] b_gear;
  logic [6:0] b_speed;
  logic [2:0] b_eff;
  logic       b_rev;
  logic       b_fault;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  speed_governor dut (
    .clk        (clk),
    .rst        (rst),
    .key_on     (key_on),
    .accel      (accel),
    .brake      (brake),
    .gear       (gear),
    .speed      (speed),
    .eff_gear   (eff_gear),
    .reverse    (reverse),
    .gear_fault (gear_fault)
  );

  speed_governor #(.TICK_DIV(4)) dut4 (
    .clk        (clk),
    .rst        (b_rst),
    .key_on     (b_key),
    .accel      (b_accel),
    .brake      (b_brake),
    .gear       (b_gear),
    .speed      (b_speed),
    .eff_gear   (b_eff),
    .reverse    (b_rev),
    .gear_fault (b_fault)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; key_on = 1'b0; accel = 1'b0;
    brake = 1'b0; gear = 3'd0;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_on = 1'b1; accel = 1'b1;
    brake = 1'b0; gear = 3'd1;
    step(3);
    n_chk++;
    if (speed !== 7'd0) begin
      n_fail++; $display("FAIL rst_speed got=%0d exp=0", speed);
    end
    n_chk++;
    if (eff_gear !== 3'd0) begin
      n_fail++; $display("FAIL rst_eff got=%0d exp=0", eff_gear);
    end
    n_chk++;
    if (reverse !== 1'b0 || gear_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags rev=%b flt=%b exp=0,0", reverse, gear_fault);
    end
  endtask

  task automatic test_gear1_accel();
    do_reset();
    key_on = 1'b1; gear = 3'd1; accel = 1'b1;
    step(1);
    n_chk++;
    if (speed !== 7'd0 || eff_gear !== 3'd1) begin
      n_fail++;
      $display("FAIL g1_start spd=%0d eff=%0d exp=0,1", speed, eff_gear);
    end
    step(10);
    n_chk++;
    if (speed !== 7'd10) begin
      n_fail++; $display("FAIL g1_ramp got=%0d exp=10", speed);
    end
    step(19);
    n_chk++;
    if (speed !== 7'd25) begin
      n_fail++; $display("FAIL g1_cap got=%0d exp=25", speed);
    end
    step(5);
    n_chk++;
    if (speed !== 7'd25 || eff_gear !== 3'd1) begin
      n_fail++;
      $display("FAIL g1_hold spd=%0d eff=%0d exp=25,1", speed, eff_gear);
    end
  endtask

  task automatic test_saturate_downshift();
    gear = 3'd5;
    step(55);
    n_chk++;
    if (speed !== 7'd80 || eff_gear !== 3'd5) begin
      n_fail++;
      $display("FAIL g5_80 spd=%0d eff=%0d exp=80,5", speed, eff_gear);
    end
    step(25);
    n_chk++;
    if (speed !== 7'd99) begin
      n_fail++; $display("FAIL g5_sat got=%0d exp=99", speed);
    end
    accel = 1'b0; gear = 3'd3;
    step(10);
    n_chk++;
    if (speed !== 7'(EB_MID) || eff_gear !== 3'd3) begin
      n_fail++;
      $display("FAIL dshift_mid spd=%0d eff=%0d exp=%0d,3",
               speed, eff_gear, EB_MID);
    end
    step(30);
    n_chk++;
    if (speed !== 7'(EB_FLOOR)) begin
      n_fail++;
      $display("FAIL dshift_end got=%0d exp=%0d", speed, EB_FLOOR);
    end
    accel = 1'b1;
    step(3);
    n_chk++;
    if (speed !== 7'(EB_FLOOR)) begin
      n_fail++;
      $display("FAIL dshift_accel got=%0d exp=%0d", speed, EB_FLOOR);
    end
    accel = 1'b0; brake = 1'b1; gear = 3'd0;
    step(5);
    n_chk++;
    if (speed !== 7'(EB_FLOOR - 5) || eff_gear !== 3'd0) begin
      n_fail++;
      $display("FAIL neutral_brk spd=%0d eff=%0d exp=%0d,0",
               speed, eff_gear, EB_FLOOR - 5);
    end
    brake = 1'b0; accel = 1'b1;
    step(3);
    n_chk++;
    if (speed !== 7'(EB_FLOOR - 5)) begin
      n_fail++;
      $display("FAIL neutral_acc got=%0d exp=%0d", speed, EB_FLOOR - 5);
    end
  endtask

  task automatic test_reverse();
    do_reset();
    key_on = 1'b1; gear = 3'd1; accel = 1'b1;
    step(11);
    n_chk++;
    if (speed !== 7'd10) begin
      n_fail++; $display("FAIL rv_pre got=%0d exp=10", speed);
    end
    gear = 3'd6;
    step(1);
    n_chk++;
    if (gear_fault !== 1'b1 || eff_gear !== 3'd0 || reverse !== 1'b0) begin
      n_fail++;
      $display("FAIL rv_fault flt=%b eff=%0d rev=%b exp=1,0,0",
               gear_fault, eff_gear, reverse);
    end
    step(3);
    n_chk++;
    if (speed !== 7'd10) begin
      n_fail++; $display("FAIL rv_accign got=%0d exp=10", speed);
    end
    accel = 1'b0; brake = 1'b1;
    step(10);
    n_chk++;
    if (speed !== 7'd0 || reverse !== 1'b0) begin
      n_fail++;
      $display("FAIL rv_stop spd=%0d rev=%b exp=0,0", speed, reverse);
    end
    step(1);
    n_chk++;
    if (reverse !== 1'b1 || gear_fault !== 1'b0 || eff_gear !== 3'd6) begin
      n_fail++;
      $display("FAIL rv_enter rev=%b flt=%b eff=%0d exp=1,0,6",
               reverse, gear_fault, eff_gear);
    end
    brake = 1'b0; accel = 1'b1;
    step(30);
    n_chk++;
    if (speed !== 7'd20 || eff_gear !== 3'd6) begin
      n_fail++;
      $display("FAIL rv_cap spd=%0d eff=%0d exp=20,6", speed, eff_gear);
    end
    gear = 3'd1;
    step(1);
    n_chk++;
    if (gear_fault !== 1'b1 || speed !== 7'd20 || eff_gear !== 3'd0) begin
      n_fail++;
      $display("FAIL rv_fwdflt flt=%b spd=%0d eff=%0d exp=1,20,0",
               gear_fault, speed, eff_gear);
    end
  endtask

  task automatic test_key_off();
    int exp_k[8];
    exp_k = '{37, 27, 17, 7, 2, 1, 0, 0};
    do_reset();
    key_on = 1'b1; gear = 3'd3; accel = 1'b1;
    step(48);
    n_chk++;
    if (speed !== 7'd47) begin
      n_fail++; $display("FAIL ko_pre got=%0d exp=47", speed);
    end
    key_on = 1'b0; accel = 1'b0;
    step(1);
    n_chk++;
    if (speed !== 7'd47 || eff_gear !== 3'd0) begin
      n_fail++;
      $display("FAIL ko_enter spd=%0d eff=%0d exp=47,0", speed, eff_gear);
    end
    brake = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      n_chk++;
      if (speed !== 7'(exp_k[i])) begin
        n_fail++;
        $display("FAIL ko_decay[%0d] got=%0d exp=%0d", i, speed, exp_k[i]);
      end
    end
  endtask

  task automatic test_brake_priority();
    do_reset();
    key_on = 1'b1; gear = 3'd2; accel = 1'b1;
    step(17);
    n_chk++;
    if (speed !== 7'd16 || eff_gear !== 3'd2) begin
      n_fail++;
      $display("FAIL bp_pre spd=%0d eff=%0d exp=16,2", speed, eff_gear);
    end
    brake = 1'b1;
    step(1);
    n_chk++;
    if (speed !== 7'd15) begin
      n_fail++; $display("FAIL bp_dec got=%0d exp=15", speed);
    end
    step(5);
    n_chk++;
    if (speed !== 7'd15) begin
      n_fail++; $display("FAIL bp_hold got=%0d exp=15", speed);
    end
  endtask

  task automatic test_tick_div();
    b_rst = 1'b1; b_key = 1'b0; b_accel = 1'b0;
    b_brake = 1'b0; b_gear = 3'd0;
    step(1);
    b_rst = 1'b0; b_key = 1'b1; b_gear = 3'd1; b_accel = 1'b1;
    step(3);
    n_chk++;
    if (b_speed !== 7'd0) begin
      n_fail++; $display("FAIL td_e3 got=%0d exp=0", b_speed);
    end
    step(1);
    n_chk++;
    if (b_speed !== 7'd1) begin
      n_fail++; $display("FAIL td_e4 got=%0d exp=1", b_speed);
    end
    step(3);
    n_chk++;
    if (b_speed !== 7'd1) begin
      n_fail++; $display("FAIL td_e7 got=%0d exp=1", b_speed);
    end
    step(1);
    n_chk++;
    if (b_speed !== 7'd2) begin
      n_fail++; $display("FAIL td_e8 got=%0d exp=2", b_speed);
    end
    step(6);
    n_chk++;
    if (b_speed !== 7'd3) begin
      n_fail++; $display("FAIL td_e14 got=%0d exp=3", b_speed);
    end
    b_rst = 1'b1;
    step(1);
    n_chk++;
    if (b_speed !== 7'd0 || b_eff !== 3'd0) begin
      n_fail++;
      $display("FAIL td_rst spd=%0d eff=%0d exp=0,0", b_speed, b_eff);
    end
    b_rst = 1'b0;
    step(3);
    n_chk++;
    if (b_speed !== 7'd0) begin
      n_fail++; $display("FAIL td_phase3 got=%0d exp=0", b_speed);
    end
    step(1);
    n_chk++;
    if (b_speed !== 7'd1) begin
      n_fail++; $display("FAIL td_phase4 got=%0d exp=1", b_speed);
    end
  endtask

  initial begin
    b_rst = 1'b1; b_key = 1'b0; b_accel = 1'b0;
    b_brake = 1'b0; b_gear = 3'd0;
    test_reset();
    test_gear1_accel();
    test_saturate_downshift();
    test_reverse();
    test_key_off();
    test_brake_priority();
    test_tick_div();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/speed_governor.md
# speed_governor

Parametrised vehicle speed governor, successor to the fixed five-gear accelerator/brake counter. Converts accel, brake, key and gear-lever inputs into a bounded speed count. Adds a configurable gear count and speed windows, a tick prescaler, a registered reverse state with a direction interlock, and optional engine braking above the current gear's window. Sits between the driver-input debouncers and the speed display / BCD conversion.

## Interface
- SPEED_W, 7, width of speed count
- MAX_SPEED, 99, absolute speed ceiling
- GEAR_W, 3, width of gear lever code
- NUM_GEARS, 5, forward gears, coded 1..NUM_GEARS
- REV_CODE, 6, lever code for reverse; must exceed NUM_GEARS
- WIN_STEP, 20, window spacing per gear
- WIN_OFS, 5, window overlap half-width
- REV_MAX, 20, reverse speed ceiling
- TICK_DIV, 1, clocks per speed update (>=1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- key_on  in  1  ignition on
- accel  in  1  accelerator held
- brake  in  1  brake held
- gear  in  GEAR_W  lever position; 0 = neutral
- speed  out  SPEED_W  current speed count
- eff_gear  out  GEAR_W  gear actually applied (0 in neutral/off/fault)
- reverse  out  1  REV state active
- gear_fault  out  1  lever requests a direction change while speed != 0

## Operation
- Window for forward gear g: hi(g) = min(WIN_STEP*g + WIN_OFS, MAX_SPEED); lo(g) = max(WIN_STEP*(g-1) - WIN_OFS, 0). Defaults: g1 0..25, g2 15..45, g3 35..65, g4 55..85, g5 75..99.
- Compute window arithmetic at SPEED_W+GEAR_W+1 bits; clamp before comparison. No wrap-around of speed in any path.
- States: OFF, FWD, REV. The state register updates every clock.
  - Any state -> OFF when key_on=0.
  - OFF -> FWD when key_on=1.
  - FWD -> REV when gear==REV_CODE and speed==0.
  - REV -> FWD when gear!=REV_CODE and speed==0.
- gear_fault = key_on & speed!=0 & ((FWD & gear==REV_CODE) | (REV & gear!=REV_CODE)). While gear_fault=1, behave as neutral.
- Per-tick speed update. Brake has priority over accel in every state.
  - OFF: brake -> speed>10: -10; else speed>5: -5; else speed>0: -1. Without brake, hold.
  - FWD, gear in 1..NUM_GEARS, no fault: brake and speed>lo -> -1; else accel and speed<hi -> +1; else speed>hi -> engine-brake rule (see Configuration); else hold. If brake is held and speed<=lo, hold (accel is ignored).
  - FWD, neutral (gear 0, gear>NUM_GEARS other than REV_CODE, or fault): brake and speed>0 -> -1; accel ignored.
  - REV, no fault: brake and speed>0 -> -1; else accel and speed<REV_MAX -> +1; else hold.
- eff_gear = gear in FWD with a valid forward gear and no fault; REV_CODE in REV with no fault; 0 otherwise.
- reverse = (state==REV).

## Timing
- Reset values: speed=0, state=OFF, eff_gear=0, reverse=0, gear_fault=0, tick counter=0.
- Tick counter counts 0..TICK_DIV-1. The tick fires on the cycle where the count is TICK_DIV-1; TICK_DIV=1 fires every cycle.
- Inputs are sampled on the tick edge. The new speed is visible one clock later.
- State, eff_gear, reverse and gear_fault are registered. They use the previous speed, so there is 1-cycle latency from input change.
- A key-off lands in OFF on the next edge. The first OFF-mode decay happens on the next tick after that.
- rst asserted mid-operation clears everything at the next edge regardless of tick phase.
- Inputs are assumed synchronised and debounced upstream.

## Configuration
- SPEED_GOV_ENGINE_BRAKE_EN defined: in FWD with a valid gear, when speed>hi(g) (after a downshift) and brake=0, speed decrements by 1 per tick until speed==hi(g). Accel is ignored while speed>hi.
- Undefined: speed>hi holds until brake is applied; accel is still ignored.

## Test plan
- Reset; key_on=1, gear=1, accel for 30 ticks -> speed climbs 0..25 and holds at 25; eff_gear=1.
- gear=5 at speed 80, accel 25 ticks -> saturates at 99. Then gear=3 with no inputs -> with macro, speed drops 1/tick to 65; without macro, holds at 99.
- FWD speed 10, gear=REV_CODE -> gear_fault=1 and accel ignored. Brake to 0 -> next clock reverse=1. Accel 30 ticks -> speed 20 max.
- key_on=0 at speed 47, brake held -> speed 37, 27, 17, 7, 2, 1, 0.
- TICK_DIV=4, gear=1, accel -> speed increments once every 4 clocks. rst asserted mid-count -> speed=0 and the phase restarts.
- gear=2 at speed 15, brake+accel held -> speed holds at 15 (brake priority, lower window bound).
